// File: rtl/dcdl_ctrl.sv
// dcdl_ctrl: bang-bang loop controller searching coarse -> fine1 -> fine2 DCDL codes and reporting lock
// Ports: clk_ext reference clock; rst_n async active-low reset; restart sync re-acquire;
//        pd_up/pd_dn phase detector decisions; T/Tb coarse thermometer code and complement;
//        T_f1/Tb_f1, T_f2/Tb_f2 fine codes and complements; Sel mode word; lock high in LOCK.
// Build option: define DCDL_CTRL_LOCK_TRACK_EN to keep stepping f2 while locked.
module dcdl_ctrl #(
   parameter int SETTLE   = 4,
   parameter int LOCK_REV = 4
) (
   input  logic        clk_ext,
   input  logic        rst_n,
   input  logic        restart,
   input  logic        pd_up,
   input  logic        pd_dn,
   output logic [15:0] T,
   output logic [15:0] Tb,
   output logic [7:0]  T_f1,
   output logic [7:0]  Tb_f1,
   output logic [7:0]  T_f2,
   output logic [7:0]  Tb_f2,
   output logic [1:0]  Sel,
   output logic        lock
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_COARSE = 3'd1;
   localparam logic [2:0] S_FINE1  = 3'd2;
   localparam logic [2:0] S_FINE2  = 3'd3;
   localparam logic [2:0] S_LOCK   = 3'd4;

   logic [2:0] state, state_n;
   logic [4:0] cc, cc_n;
   logic [3:0] f1, f1_n, f2, f2_n, rev, rev_n, rev_inc;
   logic [7:0] settle, settle_n;
   logic       has_ref, has_ref_n, ref_up, ref_up_n;
   logic       up, dn, smp, flip;

   function automatic logic [15:0] therm16(input logic [4:0] n);
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = 5'(i) < n;
      return t;
   endfunction

   function automatic logic [7:0] therm8(input logic [3:0] n);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = 4'(i) < n;
      return t;
   endfunction

   assign up      = pd_up & ~pd_dn;
   assign dn      = pd_dn & ~pd_up;
   assign smp     = (state != S_IDLE) && (settle == 8'(SETTLE - 1));
   // a decision opposite the previous non-hold decision in this state
   assign flip    = has_ref && (ref_up != up);
   assign rev_inc = rev + 4'd1;

   always_comb begin
      state_n   = state;
      cc_n      = cc;
      f1_n      = f1;
      f2_n      = f2;
      rev_n     = rev;
      has_ref_n = has_ref;
      ref_up_n  = ref_up;
      if (restart) begin
         state_n   = S_IDLE;
         cc_n      = '0;
         f1_n      = '0;
         f2_n      = '0;
         rev_n     = '0;
         has_ref_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state_n = S_COARSE;
               cc_n    = '0;
               f1_n    = '0;
               f2_n    = '0;
            end
            // saturated steps are dropped entirely, so they never count as decisions
            S_COARSE:
               if (smp && (up ? cc != 5'd16 : (dn && cc != 5'd0))) begin
                  cc_n      = up ? cc + 5'd1 : cc - 5'd1;
                  has_ref_n = 1'b1;
                  ref_up_n  = up;
                  if (flip) state_n = S_FINE1;
               end
            S_FINE1:
               if (smp && (up ? f1 != 4'd8 : (dn && f1 != 4'd0))) begin
                  f1_n      = up ? f1 + 4'd1 : f1 - 4'd1;
                  has_ref_n = 1'b1;
                  ref_up_n  = up;
                  if (flip) state_n = S_FINE2;
               end
            S_FINE2:
               if (smp && (up ? f2 != 4'd8 : (dn && f2 != 4'd0))) begin
                  f2_n      = up ? f2 + 4'd1 : f2 - 4'd1;
                  has_ref_n = 1'b1;
                  ref_up_n  = up;
                  rev_n     = flip ? rev_inc : 4'd0;
                  if (flip && rev_inc == 4'(LOCK_REV)) state_n = S_LOCK;
               end
            S_LOCK: begin
`ifdef DCDL_CTRL_LOCK_TRACK_EN
               // hitting a fine2 bound means fine1 no longer brackets the edge
               if (smp && (up || dn)) begin
                  if (up ? f2 == 4'd8 : f2 == 4'd0) begin
                     state_n = S_FINE1;
                     rev_n   = '0;
                  end else begin
                     f2_n = up ? f2 + 4'd1 : f2 - 4'd1;
                  end
               end
`endif
            end
            default: state_n = S_IDLE;
         endcase
      end
      if (state_n != state) has_ref_n = 1'b0;
      settle_n = (restart || smp || state_n != state) ? 8'd0 : settle + 8'd1;
   end

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cc      <= '0;
         f1      <= '0;
         f2      <= '0;
         rev     <= '0;
         settle  <= '0;
         has_ref <= 1'b0;
         ref_up  <= 1'b0;
         T       <= '0;
         Tb      <= '1;
         T_f1    <= '0;
         Tb_f1   <= '1;
         T_f2    <= '0;
         Tb_f2   <= '1;
         Sel     <= 2'b00;
         lock    <= 1'b0;
      end else begin
         state   <= state_n;
         cc      <= cc_n;
         f1      <= f1_n;
         f2      <= f2_n;
         rev     <= rev_n;
         settle  <= settle_n;
         has_ref <= has_ref_n;
         ref_up  <= ref_up_n;
         T       <= therm16(cc_n);
         Tb      <= ~therm16(cc_n);
         T_f1    <= therm8(f1_n);
         Tb_f1   <= ~therm8(f1_n);
         T_f2    <= therm8(f2_n);
         Tb_f2   <= ~therm8(f2_n);
         Sel     <= state_n == S_IDLE ? 2'b00 : state_n == S_COARSE ? 2'b01 :
                    state_n == S_LOCK ? 2'b11 : 2'b10;
         lock    <= state_n == S_LOCK;
      end
   end
endmodule

// File: tb/tb_dcdl_ctrl.sv
// tb_dcdl_ctrl: scoreboard bench for dcdl_ctrl with directed PD sequences
module tb_dcdl_ctrl;
  localparam int SETTLE = 4;
  logic        clk_ext = 1'b0;
  logic        rst_n = 1'b0, restart = 1'b0, pd_up = 1'b0, pd_dn = 1'b0;
  logic [15:0] T, Tb;
  logic [7:0]  T_f1, Tb_f1, T_f2, Tb_f2;
  logic [1:0]  Sel;
  logic        lock;
  dcdl_ctrl #(.SETTLE(SETTLE), .LOCK_REV(4)) dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .restart(restart), .pd_up(pd_up), .pd_dn(pd_dn),
    .T(T), .Tb(Tb), .T_f1(T_f1), .Tb_f1(Tb_f1), .T_f2(T_f2), .Tb_f2(Tb_f2),
    .Sel(Sel), .lock(lock));
  always #5 clk_ext = ~clk_ext;
  int cyc = 0;
  always @(posedge clk_ext) cyc <= cyc + 1;
  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] t;
    logic [7:0]  f1;
    logic [7:0]  f2;
    logic [1:0]  sel;
    logic        lk;
  } exp_t;
  exp_t q[$];
  int applied = 0, miscompares = 0;
  function automatic logic [15:0] th16(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction
  function automatic logic [7:0] th8(input int n);
    logic [8:0] v;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction
  always @(negedge clk_ext) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      applied++;
      if ({T, Tb, T_f1, Tb_f1, T_f2, Tb_f2, Sel, lock} !==
          {e.t, ~e.t, e.f1, ~e.f1, e.f2, ~e.f2, e.sel, e.lk}) begin
        miscompares++;
        $display("FAIL %s: got T=%h Tb=%h T_f1=%h Tb_f1=%h T_f2=%h Tb_f2=%h Sel=%b lock=%b, want T=%h Tb=%h T_f1=%h Tb_f1=%h T_f2=%h Tb_f2=%h Sel=%b lock=%b",
                 e.name, T, Tb, T_f1, Tb_f1, T_f2, Tb_f2, Sel, lock,
                 e.t, ~e.t, e.f1, ~e.f1, e.f2, ~e.f2, e.sel, e.lk);
      end
      if (Tb !== ~T || Tb_f1 !== ~T_f1 || Tb_f2 !== ~T_f2) begin
        miscompares++;
        $display("FAIL %s complement: got Tb=%h Tb_f1=%h Tb_f2=%h, want %h %h %h",
                 e.name, Tb, Tb_f1, Tb_f2, ~T, ~T_f1, ~T_f2);
      end
      if (lock !== (Sel == 2'b11)) begin
        miscompares++;
        $display("FAIL %s lock_sel: got lock=%b Sel=%b, want lock==(Sel==11)", e.name, lock, Sel);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk_ext);
    #1;
  endtask
  task automatic expect_now(input string nm, input int c, input int a, input int b,
                            input logic [1:0] s, input logic l);
    exp_t e;
    e = '{cyc, nm, th16(c), th8(a), th8(b), s, l};
    q.push_back(e);
  endtask
  task automatic smp(input logic u, input logic d, input string nm, input int c,
                     input int a, input int b, input logic [1:0] s, input logic l);
    pd_up = u;
    pd_dn = d;
    tick(SETTLE);
    expect_now(nm, c, a, b, s, l);
  endtask
  task automatic go_coarse();
    pd_up   = 1'b0;
    pd_dn   = 1'b0;
    restart = 1'b1;
    tick(1);
    expect_now("restart_idle", 0, 0, 0, 2'b00, 1'b0);
    restart = 1'b0;
    tick(1);
    expect_now("restart_coarse", 0, 0, 0, 2'b01, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  initial begin
    tick(2);
    expect_now("reset", 0, 0, 0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick(1);
    expect_now("enter_coarse", 0, 0, 0, 2'b01, 1'b0);
    for (int k = 1; k <= 18; k++) smp(1, 0, "coarse_up", k > 16 ? 16 : k, 0, 0, 2'b01, 1'b0);
    go_coarse();
    for (int k = 1; k <= 5; k++) smp(1, 0, "up5", k, 0, 0, 2'b01, 1'b0);
    smp(0, 1, "rev_to_fine1", 4, 0, 0, 2'b10, 1'b0);
    smp(1, 0, "f1_up", 4, 1, 0, 2'b10, 1'b0);
    smp(0, 1, "f1_rev", 4, 0, 0, 2'b10, 1'b0);
    smp(1, 0, "f2_ref", 4, 0, 1, 2'b10, 1'b0);
    smp(0, 1, "f2_rev1", 4, 0, 0, 2'b10, 1'b0);
    smp(1, 0, "f2_rev2", 4, 0, 1, 2'b10, 1'b0);
    smp(1, 0, "f2_same1", 4, 0, 2, 2'b10, 1'b0);
    smp(1, 0, "f2_same2", 4, 0, 3, 2'b10, 1'b0);
    smp(0, 1, "f2_rev1b", 4, 0, 2, 2'b10, 1'b0);
    smp(1, 0, "f2_rev2b", 4, 0, 3, 2'b10, 1'b0);
    smp(0, 1, "f2_rev3b", 4, 0, 2, 2'b10, 1'b0);
    smp(1, 0, "lock", 4, 0, 3, 2'b11, 1'b1);
`ifdef DCDL_CTRL_LOCK_TRACK_EN
    for (int k = 4; k <= 8; k++) smp(1, 0, "lock_track", 4, 0, k, 2'b11, 1'b1);
    smp(1, 0, "lock_exit", 4, 0, 8, 2'b10, 1'b0);
`else
    for (int k = 0; k < 3; k++) smp(1, 0, "lock_frozen_up", 4, 0, 3, 2'b11, 1'b1);
    smp(0, 1, "lock_frozen_dn", 4, 0, 3, 2'b11, 1'b1);
`endif
    go_coarse();
    for (int k = 1; k <= 3; k++) smp(1, 0, "hold_pre", k, 0, 0, 2'b01, 1'b0);
    for (int k = 0; k < 10; k++) smp(1, 1, "hold_both", 3, 0, 0, 2'b01, 1'b0);
    smp(0, 0, "hold_none", 3, 0, 0, 2'b01, 1'b0);
    smp(0, 1, "hold_then_rev", 2, 0, 0, 2'b10, 1'b0);
    go_coarse();
    smp(1, 0, "rs_c_up", 1, 0, 0, 2'b01, 1'b0);
    smp(0, 1, "rs_c_rev", 0, 0, 0, 2'b10, 1'b0);
    smp(1, 0, "rs_f1_up", 0, 1, 0, 2'b10, 1'b0);
    smp(0, 1, "rs_f1_rev", 0, 0, 0, 2'b10, 1'b0);
    smp(1, 0, "rs_f2_up", 0, 0, 1, 2'b10, 1'b0);
    tick(2);
    restart = 1'b1;
    tick(1);
    expect_now("restart_fine2", 0, 0, 0, 2'b00, 1'b0);
    restart = 1'b0;
    tick(1);
    expect_now("restart_resume", 0, 0, 0, 2'b01, 1'b0);
    smp(1, 0, "restart_first", 1, 0, 0, 2'b01, 1'b0);
    go_coarse();
    for (int k = 1; k <= 3; k++) smp(1, 0, "ar_up", k, 0, 0, 2'b01, 1'b0);
    tick(2);
    rst_n = 1'b0;
    expect_now("async_reset", 0, 0, 0, 2'b00, 1'b0);
    tick(2);
    expect_now("reset_hold", 0, 0, 0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick(1);
    expect_now("reset_resume", 0, 0, 0, 2'b01, 1'b0);
    smp(1, 0, "reset_first", 1, 0, 0, 2'b01, 1'b0);
    tick(3);
    while (q.size() > 0) begin
      miscompares++;
      $display("FAIL %s: got unchecked, want checked", q[0].name);
      void'(q.pop_front());
    end
    if (miscompares == 0) $display("PASS");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/dcdl_ctrl.md
# dcdl_ctrl

Digital loop controller that drives the DCDL delay line from a bang-bang phase detector. It runs a coarse→fine1→fine2 binary-free linear search and reports lock. It produces the 16-bit coarse thermometer code, the two 8-bit fine thermometer codes, their complements, and the `Sel` mode word consumed by the delay line. It sits between the phase detector output and the DCDL control inputs, clocked by the external reference clock.

## Interface
- `SETTLE`, 4: reference cycles between successive PD samples (loop settling); legal 2..255.
- `LOCK_REV`, 4: consecutive direction reversals in FINE2 required to declare lock; legal 1..15.
- `clk_ext`  in  1  reference clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `restart`  in  1  synchronous re-acquisition request, level-sampled each cycle.
- `pd_up`  in  1  PD: delay too short, increase delay.
- `pd_dn`  in  1  PD: delay too long, decrease delay.
- `T`, `Tb`  out  16  coarse thermometer code and bitwise complement.
- `T_f1`, `Tb_f1`  out  8  fine stage 1 code and complement.
- `T_f2`, `Tb_f2`  out  8  fine stage 2 code and complement.
- `Sel`  out  2  mode: 00 idle, 01 coarse acquisition, 10 fine, 11 locked.
- `lock`  out  1  high while in LOCK.

## Operation
- Internal counts: `cc` 0..16, `f1` 0..8, `f2` 0..8. Outputs are thermometer, LSB-first: `T[i]=(i<cc)`, likewise fine. Complements are always exact `~` of the true code; all outputs registered.
- Decision per sample: up only = +1, dn only = −1, both or neither = hold (no count change, no reversal bookkeeping).
- Settle counter counts 0..SETTLE−1, sample taken when it equals SETTLE−1, then wraps to 0. It clears on every state change.
- States: IDLE (Sel 00) → COARSE (01) → FINE1 (10) → FINE2 (10) → LOCK (11).
- IDLE: counts cleared (`cc=f1=f2=0`); moves to COARSE the cycle after reset deassertion.
- COARSE: step `cc`. Saturates at 0 and 16 (step beyond is ignored, no transition). First non-hold decision in a state sets the reference direction; a decision opposite the previous non-hold decision is a reversal → go to FINE1, `cc` keeps the reversed value.
- FINE1: same rule on `f1` → FINE2 on first reversal.
- FINE2: step `f2`; reversal counter increments on each reversal, clears on a same-direction decision. Reaching LOCK_REV → LOCK.
- LOCK: `lock=1`. If `f2` is at 8 with up or at 0 with dn, drop to FINE1 (lock=0, `f2` unchanged, reversal count cleared).
- `restart=1` in any state: next cycle IDLE with all counts cleared; takes priority over any sample in that cycle.

## Timing
- Reset values: `T=0`, `Tb=16'hFFFF`, `T_f1=T_f2=0`, `Tb_f1=Tb_f2=8'hFF`, `Sel=00`, `lock=0`, state IDLE, settle and reversal counters 0.
- Sample at cycle k → updated codes, Sel and lock visible after the rising edge ending cycle k (1-cycle latency).
- First COARSE sample occurs SETTLE cycles after entering COARSE; same for each state entry.
- Reset assertion mid-search forces reset values immediately (async), regardless of clock.
- `pd_up`/`pd_dn` are assumed synchronous to `clk_ext` (PD already retimed); only the sample-cycle value matters.

## Configuration
- `DCDL_CTRL_LOCK_TRACK_EN` defined: LOCK keeps stepping `f2` every SETTLE cycles per the rules above, including bound-exit to FINE1.
- Undefined: codes are frozen in LOCK; PD inputs ignored until `restart` or reset; `lock` stays 1.

## Test plan
- Reset then constant `pd_up`, SETTLE=4 → `cc` increments every 4 cycles, `T` reaches 16'hFFFF at cc=16 and stays; Sel=01, no transition.
- Up ×5 then dn → `cc` 5 then 4, state FINE1, `T=16'h000F`, `Tb=16'hFFF0`, Sel=10.
- In FINE2, alternate up/dn with LOCK_REV=4 → lock=1, Sel=11 one cycle after the 4th reversal; inserting two same-direction ups midway restarts the count.
- pd_up=pd_dn=1 for 10 samples in COARSE → all codes unchanged, state unchanged.
- Tracking build, LOCK with `f2=8`, pd_up → next cycle lock=0, Sel=10, state FINE1, `T_f2=8'hFF`; non-tracking build → codes frozen, lock stays 1.
- `restart` pulse during FINE2, and `rst_n` low mid-COARSE → all outputs at reset values (restart: next edge; rst_n: immediately), search resumes from cc=0.
